button_pio_irq: RTL and testbench

BUTTON_PIO_IRQ -- requirements
Module: button_pio_irq

---
 rtl/button_pio_irq.sv | 104 ++++++++++
 tb/tb_button_pio_irq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/button_pio_irq.sv
// Debounced button PIO with edge capture and masked level interrupt.
// Avalon-MM slave: 0 DATA, 1 reserved, 2 IRQMASK, 3 EDGECAPTURE (write-1-to-clear).
module button_pio_irq #(
  parameter int WIDTH     = 2,
  parameter int EDGE_TYPE = 1,
  parameter int DEBOUNCE  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CW = $clog2(DEBOUNCE) + 1;
  localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE - 1);

  logic [WIDTH-1:0] sync1_q, sync_q;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [WIDTH-1:0] deb_dly_q;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;

  logic [WIDTH-1:0] rise, fall, edge_det, clr;
  logic             wr_en;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;

  // A bit only changes after DEBOUNCE consecutive cycles of disagreement.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_TC) deb_d[i] = sync_q[i];
        else                    cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  assign rise = deb_q & ~deb_dly_q;
  assign fall = ~deb_q & deb_dly_q;

  always_comb begin
    if (EDGE_TYPE == 0)      edge_det = rise;
    else if (EDGE_TYPE == 1) edge_det = fall;
    else                     edge_det = rise | fall;
  end

  assign wr_en = chipselect & ~write_n;
  assign clr   = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  // Set is OR'd in after the clear so a same-cycle edge is never lost.
  assign edgecap_d = (edgecap_q & ~clr) | edge_det;
  assign mask_d    = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : mask_q;
  assign irq_d     = |(edgecap_q & mask_q);

  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0:    readdata_d = 32'(deb_q);
      2'd2:    readdata_d = 32'(mask_q);
      2'd3:    readdata_d = 32'(edgecap_q);
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync_q     <= '0;
      deb_q      <= '0;
      deb_dly_q  <= '0;
      edgecap_q  <= '0;
      mask_q     <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q    <= in_port;
      sync_q     <= sync1_q;
      deb_q      <= deb_d;
      deb_dly_q  <= deb_q;
      edgecap_q  <= edgecap_d;
      mask_q     <= mask_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_button_pio_irq.sv
// Directed bench for button_pio_irq with WIDTH=2, DEBOUNCE=4, falling-edge capture.
module tb_button_pio_irq;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [1:0]  in_port;
  logic [31:0] readdata;
  logic        irq;
  logic [31:0] d;

  int n_total = 0;
  int n_bad   = 0;

  button_pio_irq #(.WIDTH(2), .EDGE_TYPE(1), .DEBOUNCE(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    address    = a;
    writedata  = v;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    address = a;
    @(negedge clk);
    v = readdata;
  endtask

  initial begin
    reset_n    = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 2'b00;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    cyc(3);
    reset_n = 1'b1;
    cyc(1);

    // Mask bit0, then step both inputs high and check exact debounce latency.
    wr(2'd2, 32'd1);
    rd(2'd2, d); chk("mask_rd", d, 32'd1);
    address = 2'd0;
    in_port = 2'b11;
    cyc(6); chk("lat_pre", readdata, 32'd0);
    cyc(1); chk("data_11", readdata, 32'd3);
    rd(2'd3, d); chk("ec_after_rise", d, 32'd0);
    chk("irq_after_rise", {31'd0, irq}, 32'd0);

    // Falling edge on bit0: capture then irq one cycle later.
    address = 2'd3;
    in_port = 2'b10;
    cyc(7);
    chk("irq_pre", {31'd0, irq}, 32'd0);
    chk("ec_pre", readdata, 32'd0);
    cyc(1);
    chk("irq_set", {31'd0, irq}, 32'd1);
    chk("ec_fall", readdata, 32'd1);
    rd(2'd0, d); chk("data_10", d, 32'd2);
    wr(2'd3, 32'd1);
    chk("irq_hold", {31'd0, irq}, 32'd1);
    cyc(1); chk("irq_clr", {31'd0, irq}, 32'd0);
    rd(2'd3, d); chk("ec_clr", d, 32'd0);

    // Three-cycle glitch must be filtered.
    in_port = 2'b11;
    cyc(3);
    in_port = 2'b10;
    cyc(10);
    rd(2'd0, d); chk("glitch_data", d, 32'd2);
    rd(2'd3, d); chk("glitch_ec", d, 32'd0);
    chk("glitch_irq", {31'd0, irq}, 32'd0);

    // Rising edges are not captured in falling mode.
    in_port = 2'b11;
    cyc(10);
    rd(2'd0, d); chk("rise_data", d, 32'd3);
    rd(2'd3, d); chk("rise_no_ec", d, 32'd0);

    // Set wins over a same-cycle clear.
    in_port = 2'b10;
    cyc(10);
    rd(2'd3, d); chk("prep_ec", d, 32'd1);
    chk("prep_irq", {31'd0, irq}, 32'd1);
    in_port = 2'b11;
    cyc(10);
    in_port = 2'b10;
    cyc(6);
    wr(2'd3, 32'd1);
    rd(2'd3, d); chk("set_wins", d, 32'd1);
    rd(2'd0, d); chk("sw_data", d, 32'd2);
    wr(2'd3, 32'd1);
    rd(2'd3, d); chk("ec_clr2", d, 32'd0);

    // Mask gating and register map.
    wr(2'd2, 32'd0);
    in_port = 2'b00;
    cyc(10);
    rd(2'd3, d); chk("ec_bit1", d, 32'd2);
    chk("irq_masked", {31'd0, irq}, 32'd0);
    wr(2'd2, 32'd2);
    chk("irq_lag", {31'd0, irq}, 32'd0);
    cyc(1); chk("irq_unmask", {31'd0, irq}, 32'd1);
    rd(2'd1, d); chk("rd_addr1", d, 32'd0);
    rd(2'd2, d); chk("rd_mask2", d, 32'd2);
    wr(2'd1, 32'd3);
    rd(2'd2, d); chk("addr1_wr_mask", d, 32'd2);
    rd(2'd3, d); chk("addr1_wr_ec", d, 32'd2);
    rd(2'd0, d); chk("data_00", d, 32'd0);
    wr(2'd2, 32'hFFFF_FFFE);
    rd(2'd2, d); chk("mask_upper", d, 32'd2);

    // Asynchronous reset mid-count with irq high.
    in_port = 2'b01;
    cyc(3);
    chk("pre_rst_irq", {31'd0, irq}, 32'd1);
    chk("pre_rst_rd", readdata, 32'd2);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_rd", readdata, 32'd0);
    chk("arst_irq", {31'd0, irq}, 32'd0);
    in_port = 2'b00;
    cyc(3);
    reset_n = 1'b1;
    cyc(10);
    rd(2'd3, d); chk("post_rst_ec", d, 32'd0);
    rd(2'd2, d); chk("post_rst_mask", d, 32'd0);
    rd(2'd0, d); chk("post_rst_data", d, 32'd0);
    chk("post_rst_irq", {31'd0, irq}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
